// File: rtl/traffic_light_ctrl.sv
// Two-way intersection sequencer. Steps main and side roads through
// green / yellow / all-red phases counted in ticks, shortens main green
// on a pedestrian request, and supports a night flashing-amber mode.
// Every output is decoded from the state, count and flash registers.
module traffic_light_ctrl #(
   parameter int unsigned T_GREEN_MAIN = 30,
   parameter int unsigned T_GREEN_SIDE = 20,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_ALLRED     = 1,
   parameter int unsigned T_PED_MIN    = 5,
   parameter int unsigned CW           = 8
) (
   input  logic          I_CLK,
   input  logic          I_RST_N,
   input  logic          I_TICK,
   input  logic          I_MODE,
   input  logic          I_PED_REQ,
   output logic [2:0]    O_MAIN_RYG,
   output logic [2:0]    O_SIDE_RYG,
   output logic          O_PED_WALK,
   output logic [CW-1:0] O_COUNT,
   output logic [2:0]    O_STATE
);

   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALLRED_A    = 3'd2,
      SIDE_GREEN  = 3'd3,
      SIDE_YELLOW = 3'd4,
      ALLRED_B    = 3'd5,
      FLASH       = 3'd6
   } state_e;

   localparam logic [CW-1:0] C_GREEN_MAIN = CW'(T_GREEN_MAIN);
   localparam logic [CW-1:0] C_GREEN_SIDE = CW'(T_GREEN_SIDE);
   localparam logic [CW-1:0] C_YELLOW     = CW'(T_YELLOW);
   localparam logic [CW-1:0] C_ALLRED     = CW'(T_ALLRED);
   localparam logic [CW-1:0] C_PED_MIN    = CW'(T_PED_MIN);
   localparam logic [CW-1:0] C_ONE        = CW'(1);

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ped_pend_q, ped_pend_d;
   logic            flash_q, flash_d;

   // Next-state, countdown, pedestrian latch and flash phase.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      count_d    = count_q;
      flash_d    = flash_q;
      ped_pend_d = ped_pend_q | I_PED_REQ;

      if (I_TICK) begin
         if (state_q == FLASH) begin
            if (!I_MODE) begin
               flash_d = ~flash_q;
            end else begin
               state_d = ALLRED_B;
               count_d = C_ALLRED;
               flash_d = 1'b0;
            end
         end else if (!I_MODE) begin
            // Night mode wins over a phase that would expire on this tick.
            state_d = FLASH;
            count_d = '0;
            flash_d = 1'b1;
         end else if (count_q <= C_ONE) begin
            unique case (state_q)
               MAIN_GREEN:  begin state_d = MAIN_YELLOW; count_d = C_YELLOW;     end
               MAIN_YELLOW: begin state_d = ALLRED_A;    count_d = C_ALLRED;     end
               ALLRED_A:    begin state_d = SIDE_GREEN;  count_d = C_GREEN_SIDE; end
               SIDE_GREEN:  begin state_d = SIDE_YELLOW; count_d = C_YELLOW;     end
               SIDE_YELLOW: begin state_d = ALLRED_B;    count_d = C_ALLRED;     end
               default:     begin state_d = MAIN_GREEN;  count_d = C_GREEN_MAIN; end
            endcase
         end else if (state_q == MAIN_GREEN && ped_pend_q && count_q > C_PED_MIN) begin
            count_d = C_PED_MIN;
         end else begin
            count_d = count_q - C_ONE;
         end
      end

      // The request is served by entering side green; flash mode drops it.
      if (state_q == FLASH || state_d == FLASH ||
          (state_d == SIDE_GREEN && state_q != SIDE_GREEN)) begin
         ped_pend_d = 1'b0;
      end
   end

   // State registers; reset parks the junction in all-red before main green.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         // NOTE: sequential state uses non-blocking (<=) so all registers update together.
         state_q    <= ALLRED_B;
         count_q    <= C_ALLRED;
         ped_pend_q <= 1'b0;
         flash_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         ped_pend_q <= ped_pend_d;
         flash_q    <= flash_d;
      end
   end

   // Lamp decode from registered state; at most one lamp per road.
   always_comb begin
      O_MAIN_RYG = LAMP_R;
      O_SIDE_RYG = LAMP_R;
      O_PED_WALK = 1'b0;
      unique case (state_q)
         MAIN_GREEN:  O_MAIN_RYG = LAMP_G;
         MAIN_YELLOW: O_MAIN_RYG = LAMP_Y;
         SIDE_GREEN:  begin O_SIDE_RYG = LAMP_G; O_PED_WALK = 1'b1; end
         SIDE_YELLOW: O_SIDE_RYG = LAMP_Y;
         FLASH: begin
            O_MAIN_RYG = {1'b0, flash_q, 1'b0};
            O_SIDE_RYG = {1'b0, flash_q, 1'b0};
         end
         default: ;
      endcase
   end

   assign O_COUNT = count_q;
   assign O_STATE = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and random bench for traffic_light_ctrl with small phase
// durations. Expected outputs are queued as each stimulus step is driven
// and popped when the DUT result is sampled on the falling clock edge.
module tb_traffic_light_ctrl;

   logic       I_CLK = 1'b0;
   logic       I_RST_N;
   logic       I_TICK;
   logic       I_MODE;
   logic       I_PED_REQ;
   logic [2:0] O_MAIN_RYG;
   logic [2:0] O_SIDE_RYG;
   logic       O_PED_WALK;
   logic [7:0] O_COUNT;
   logic [2:0] O_STATE;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0] st;
      logic [7:0] cnt;
      logic [2:0] m;
      logic [2:0] s;
      logic       w;
   } exp_t;

   exp_t sb[$];

   traffic_light_ctrl #(
      .T_GREEN_MAIN (5),
      .T_GREEN_SIDE (4),
      .T_YELLOW     (2),
      .T_ALLRED     (1),
      .T_PED_MIN    (2),
      .CW           (8)
   ) dut (
      .I_CLK      (I_CLK),
      .I_RST_N    (I_RST_N),
      .I_TICK     (I_TICK),
      .I_MODE     (I_MODE),
      .I_PED_REQ  (I_PED_REQ),
      .O_MAIN_RYG (O_MAIN_RYG),
      .O_SIDE_RYG (O_SIDE_RYG),
      .O_PED_WALK (O_PED_WALK),
      .O_COUNT    (O_COUNT),
      .O_STATE    (O_STATE)
   );

   always #5 I_CLK = ~I_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected lamps come from the state-to-lamp table of the intersection.
   task automatic expect_out(input logic [2:0] st, input logic [7:0] cnt, input logic fp);
      exp_t e;
      e.st  = st;
      e.cnt = cnt;
      e.w   = (st == 3'd3);
      case (st)
         3'd0:    begin e.m = 3'b001; e.s = 3'b100; end
         3'd1:    begin e.m = 3'b010; e.s = 3'b100; end
         3'd3:    begin e.m = 3'b100; e.s = 3'b001; end
         3'd4:    begin e.m = 3'b100; e.s = 3'b010; end
         3'd6:    begin e.m = {1'b0, fp, 1'b0}; e.s = {1'b0, fp, 1'b0}; end
         default: begin e.m = 3'b100; e.s = 3'b100; end
      endcase
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      chk({tag, "/queue"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "/state"}, 32'(O_STATE),    32'(e.st));
         chk({tag, "/count"}, 32'(O_COUNT),    32'(e.cnt));
         chk({tag, "/main"},  32'(O_MAIN_RYG), 32'(e.m));
         chk({tag, "/side"},  32'(O_SIDE_RYG), 32'(e.s));
         chk({tag, "/walk"},  32'(O_PED_WALK), 32'(e.w));
      end
   endtask

   // One tick with the given mode, then check the result one cycle later.
   task automatic do_tick(input logic mode, input logic [2:0] st, input logic [7:0] cnt,
                          input logic fp, input string tag);
      @(negedge I_CLK);
      I_MODE = mode;
      I_TICK = 1'b1;
      expect_out(st, cnt, fp);
      @(negedge I_CLK);
      I_TICK = 1'b0;
      check_out(tag);
      @(negedge I_CLK);
   endtask

   initial begin
      I_RST_N   = 1'b0;
      I_TICK    = 1'b0;
      I_MODE    = 1'b1;
      I_PED_REQ = 1'b0;
      #12;
      expect_out(3'd5, 8'd1, 1'b0);
      check_out("reset");
      @(negedge I_CLK);
      I_RST_N = 1'b1;
      @(negedge I_CLK);
      expect_out(3'd5, 8'd1, 1'b0);
      check_out("after_release");

      // Full normal cycle; first tick also checks nothing moves before the edge.
      I_TICK = 1'b1;
      #1;
      chk("latency/pre_edge", 32'(O_STATE), 32'd5);
      expect_out(3'd0, 8'd5, 1'b0);
      @(negedge I_CLK);
      I_TICK = 1'b0;
      check_out("seq/t1");
      @(negedge I_CLK);
      do_tick(1'b1, 3'd0, 8'd4, 1'b0, "seq/t2");
      do_tick(1'b1, 3'd0, 8'd3, 1'b0, "seq/t3");
      do_tick(1'b1, 3'd0, 8'd2, 1'b0, "seq/t4");
      do_tick(1'b1, 3'd0, 8'd1, 1'b0, "seq/t5");
      do_tick(1'b1, 3'd1, 8'd2, 1'b0, "seq/t6");
      do_tick(1'b1, 3'd1, 8'd1, 1'b0, "seq/t7");
      do_tick(1'b1, 3'd2, 8'd1, 1'b0, "seq/t8");
      do_tick(1'b1, 3'd3, 8'd4, 1'b0, "seq/t9");
      do_tick(1'b1, 3'd3, 8'd3, 1'b0, "seq/t10");
      do_tick(1'b1, 3'd3, 8'd2, 1'b0, "seq/t11");
      do_tick(1'b1, 3'd3, 8'd1, 1'b0, "seq/t12");
      do_tick(1'b1, 3'd4, 8'd2, 1'b0, "seq/t13");
      do_tick(1'b1, 3'd4, 8'd1, 1'b0, "seq/t14");
      do_tick(1'b1, 3'd5, 8'd1, 1'b0, "seq/t15");
      do_tick(1'b1, 3'd0, 8'd5, 1'b0, "seq/t16");

      // Pedestrian pulse at count 5 without a tick: nothing moves yet.
      @(negedge I_CLK);
      I_PED_REQ = 1'b1;
      @(negedge I_CLK);
      I_PED_REQ = 1'b0;
      expect_out(3'd0, 8'd5, 1'b0);
      check_out("ped/no_tick");
      do_tick(1'b1, 3'd0, 8'd2, 1'b0, "ped/truncate");
      do_tick(1'b1, 3'd0, 8'd1, 1'b0, "ped/dec");
      do_tick(1'b1, 3'd1, 8'd2, 1'b0, "ped/yellow");
      do_tick(1'b1, 3'd1, 8'd1, 1'b0, "ped/y1");
      do_tick(1'b1, 3'd2, 8'd1, 1'b0, "ped/allred");
      do_tick(1'b1, 3'd3, 8'd4, 1'b0, "ped/side");
      do_tick(1'b1, 3'd3, 8'd3, 1'b0, "ped/s3");
      do_tick(1'b1, 3'd3, 8'd2, 1'b0, "ped/s2");
      do_tick(1'b1, 3'd3, 8'd1, 1'b0, "ped/s1");
      do_tick(1'b1, 3'd4, 8'd2, 1'b0, "ped/sy2");
      do_tick(1'b1, 3'd4, 8'd1, 1'b0, "ped/sy1");
      do_tick(1'b1, 3'd5, 8'd1, 1'b0, "ped/arb");
      do_tick(1'b1, 3'd0, 8'd5, 1'b0, "ped/mg5");
      do_tick(1'b1, 3'd0, 8'd4, 1'b0, "ped/cleared");
      do_tick(1'b1, 3'd0, 8'd3, 1'b0, "ped/mg3");
      do_tick(1'b1, 3'd0, 8'd2, 1'b0, "ped/mg2");

      // Request at count 2 (== T_PED_MIN): plain decrement.
      @(negedge I_CLK);
      I_PED_REQ = 1'b1;
      @(negedge I_CLK);
      I_PED_REQ = 1'b0;
      do_tick(1'b1, 3'd0, 8'd1, 1'b0, "ped_min/no_trunc");
      do_tick(1'b1, 3'd1, 8'd2, 1'b0, "ped_min/yellow");
      do_tick(1'b1, 3'd1, 8'd1, 1'b0, "ped_min/y1");
      do_tick(1'b1, 3'd2, 8'd1, 1'b0, "ped_min/allred");
      do_tick(1'b1, 3'd3, 8'd4, 1'b0, "ped_min/side");
      do_tick(1'b1, 3'd3, 8'd3, 1'b0, "ped_min/s3");
      do_tick(1'b1, 3'd3, 8'd2, 1'b0, "ped_min/s2");
      do_tick(1'b1, 3'd3, 8'd1, 1'b0, "ped_min/s1");

      // Night mode on the expiring side-green tick wins over SIDE_YELLOW.
      do_tick(1'b0, 3'd6, 8'd0, 1'b1, "flash/enter");
      do_tick(1'b0, 3'd6, 8'd0, 1'b0, "flash/off");
      do_tick(1'b0, 3'd6, 8'd0, 1'b1, "flash/on");
      do_tick(1'b1, 3'd5, 8'd1, 1'b0, "flash/exit");
      do_tick(1'b1, 3'd0, 8'd5, 1'b0, "flash/main");
      do_tick(1'b1, 3'd0, 8'd4, 1'b0, "rst_prep/4");
      do_tick(1'b1, 3'd0, 8'd3, 1'b0, "rst_prep/3");
      do_tick(1'b1, 3'd0, 8'd2, 1'b0, "rst_prep/2");
      do_tick(1'b1, 3'd0, 8'd1, 1'b0, "rst_prep/1");
      do_tick(1'b1, 3'd1, 8'd2, 1'b0, "rst_prep/yellow");

      // Asynchronous reset between clock edges mid-yellow.
      @(posedge I_CLK);
      #2;
      I_RST_N = 1'b0;
      #1;
      expect_out(3'd5, 8'd1, 1'b0);
      check_out("async_rst");
      @(negedge I_CLK);
      I_RST_N = 1'b1;
      @(negedge I_CLK);
      expect_out(3'd5, 8'd1, 1'b0);
      check_out("async_rst/released");
      do_tick(1'b1, 3'd0, 8'd5, 1'b0, "async_rst/resume");

      // Mode and pedestrian toggling without ticks changes nothing.
      for (int i = 0; i < 6; i++) begin
         @(negedge I_CLK);
         I_MODE    = i[0];
         I_PED_REQ = ~i[0];
      end
      @(negedge I_CLK);
      I_MODE    = 1'b1;
      I_PED_REQ = 1'b0;
      expect_out(3'd0, 8'd5, 1'b0);
      check_out("idle/no_change");
      do_tick(1'b1, 3'd0, 8'd2, 1'b0, "idle/ped_kept");
      do_tick(1'b1, 3'd0, 8'd1, 1'b0, "idle/dec");

      // Random stimulus with safety checks every cycle.
      for (int i = 0; i < 10000; i++) begin
         @(negedge I_CLK);
         chk("rand/no_conflict",
             32'(O_STATE == 3'd6 || O_MAIN_RYG == 3'b100 || O_SIDE_RYG == 3'b100), 32'd1);
         chk("rand/main_onehot0", 32'($onehot0(O_MAIN_RYG)), 32'd1);
         chk("rand/side_onehot0", 32'($onehot0(O_SIDE_RYG)), 32'd1);
         chk("rand/walk", 32'(O_PED_WALK), 32'(O_STATE == 3'd3));
         chk("rand/count_nonzero", 32'(O_STATE == 3'd6 || O_COUNT != 8'd0), 32'd1);
         chk("rand/state_range", 32'(O_STATE <= 3'd6), 32'd1);
         I_TICK    = ($urandom_range(0, 3) == 0);
         I_MODE    = ($urandom_range(0, 7) != 0);
         I_PED_REQ = ($urandom_range(0, 15) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-way intersection sequencer for the traffic-light design. It consumes the 1-cycle tick produced from the frequency divider's slow output. It steps main and side roads through green/yellow/all-red phases, with per-phase durations set by parameters. It also handles a pedestrian request and a night flashing-amber mode, and drives the remaining-seconds value to the countdown display.

Parameters:
T_GREEN_MAIN, 30, main-road green duration in ticks (>=1)
T_GREEN_SIDE, 20, side-road green duration in ticks (>=1)
T_YELLOW, 3, yellow duration in ticks for both roads (>=1)
T_ALLRED, 1, all-red clearance duration in ticks (>=1)
T_PED_MIN, 5, main-green remaining ticks after a pedestrian request truncates the phase (>=1)
CW, 8, countdown width; every T_* must be < 2^CW

Ports:
I_CLK  in  1  system clock, all state on rising edge
I_RST_N  in  1  asynchronous active-low reset
I_TICK  in  1  one-I_CLK-cycle enable pulse, nominally 1 Hz; all timing is counted in ticks
I_MODE  in  1  1 = normal sequence, 0 = night flash; sampled only when I_TICK=1
I_PED_REQ  in  1  pedestrian button, level or pulse; captured on any cycle
O_MAIN_RYG  out  3  main lamps {R,Y,G}, one-hot or 000
O_SIDE_RYG  out  3  side lamps {R,Y,G}, one-hot or 000
O_PED_WALK  out  1  walk lamp, high only in SIDE_GREEN
O_COUNT  out  CW  ticks remaining in current phase; 0 in FLASH
O_STATE  out  3  state code, for debug/display

Behaviour:
- States and codes:
  - MAIN_GREEN = 0, MAIN_YELLOW = 1, ALLRED_A = 2, SIDE_GREEN = 3, SIDE_YELLOW = 4, ALLRED_B = 5, FLASH = 6.
- Lamps:
  - MAIN_GREEN: main G, side R.
  - MAIN_YELLOW: main Y, side R.
  - ALLRED_A/B: both R.
  - SIDE_GREEN: main R, side G.
  - SIDE_YELLOW: main R, side Y.
  - FLASH: both roads Y = flash_phase, R = G = 0.
- Normal sequence: MAIN_GREEN -> MAIN_YELLOW -> ALLRED_A -> SIDE_GREEN -> SIDE_YELLOW -> ALLRED_B -> MAIN_GREEN.
- Counter: on entering a phase, count loads that phase's T_*. Each I_TICK decrements it. A tick seen with count==1 transitions to the next phase and loads the next duration. Each phase therefore lasts exactly T ticks, and O_COUNT runs T..1.
- No I_TICK means no change, whatever the other inputs do.
- All outputs are registered and are driven from the state/count registers. A change appears after the I_CLK edge that samples I_TICK=1, i.e. one cycle of latency from the tick.
- Pedestrian request:
  - ped_pend is set on any cycle with I_PED_REQ=1.
  - It is cleared on entry to SIDE_GREEN, and cleared in FLASH.
  - In MAIN_GREEN, a tick with ped_pend=1 and count > T_PED_MIN loads count = T_PED_MIN instead of decrementing.
  - Otherwise the tick decrements normally; no truncation happens below T_PED_MIN.
- Night mode:
  - A tick with I_MODE=0 in any normal state goes to FLASH with flash_phase=1 and count=0. Mode has priority over countdown expiry on the same tick.
  - In FLASH, each tick with I_MODE=0 toggles flash_phase.
  - A tick with I_MODE=1 in FLASH goes to ALLRED_B with count=T_ALLRED, then continues to MAIN_GREEN normally.
- Reset (async assert, sync release by the system):
  - state=ALLRED_B, count=T_ALLRED, ped_pend=0, flash_phase=0.
  - O_MAIN_RYG=100, O_SIDE_RYG=100, O_PED_WALK=0, O_COUNT=T_ALLRED, O_STATE=5.
  - Reset mid-phase abandons the phase immediately, with no yellow.
- Safety invariant: main and side are never both non-red except in FLASH. Never more than one lamp is lit per road.
- Arithmetic: count is unsigned CW bits. Decrement never goes below 1 in normal states. Outside FLASH, count==0 is unreachable.

Test Plan:
Parameters for all scenarios: T_GREEN_MAIN=5, T_GREEN_SIDE=4, T_YELLOW=2, T_ALLRED=1, T_PED_MIN=2.
- Reset, then I_MODE=1 with 16 ticks spaced 3 cycles apart -> O_STATE follows 5,0×5,1×2,2,3×4,4×2,5,0. O_COUNT runs 5,4,3,2,1 in MAIN_GREEN. O_PED_WALK is high only for the 4 SIDE_GREEN ticks. One cycle of latency after each tick.
- Pulse I_PED_REQ with no tick while in MAIN_GREEN at O_COUNT=5 -> next tick loads O_COUNT=2. Two more ticks reach MAIN_YELLOW. ped_pend clears on SIDE_GREEN entry. Repeat with the request at O_COUNT=2 -> normal decrement to 1.
- I_MODE=0 on a tick during SIDE_GREEN count=1 -> FLASH (O_STATE=6), not SIDE_YELLOW. Lamps 010/010, then 000/000 on the next tick, alternating. O_COUNT=0.
- From FLASH, I_MODE=1 on a tick -> ALLRED_B (100/100, O_COUNT=1), then MAIN_GREEN with O_COUNT=5 on the following tick.
- Assert I_RST_N=0 asynchronously mid-MAIN_YELLOW, between clock edges -> outputs go to 100/100, O_COUNT=1, O_STATE=5 without waiting for an I_CLK edge. After release, the sequence resumes from ALLRED_B.
- I_MODE and I_PED_REQ toggle between ticks with I_TICK=0 -> no state/count change. An assertion checks the safety invariant over 10k random-stimulus cycles.
